// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit with architectural HI/LO.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle. Signed operations run on magnitudes and fix signs in a final cycle.
module mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] opr_a_mdu_i,
  input  logic [WIDTH-1:0] opr_b_mdu_i,
  input  logic [2:0]       op_mdu_i,
  input  logic             start_mdu_i,
  output logic             busy_mdu_o,
  output logic             done_mdu_o,
  output logic [WIDTH-1:0] hi_mdu_o,
  output logic [WIDTH-1:0] lo_mdu_o
);

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t state_q, state_d;

  // Control strobes
  logic launch, mt_hi_wr, mt_lo_wr, iterate, finish;

  // Datapath state: opnd = multiplicand/divisor, acc = product high/remainder,
  // low = multiplier (shifted out as product low)/dividend (becomes quotient)
  logic [WIDTH-1:0] opnd_q, acc_q, low_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  // Launch-time operand conditioning
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Iteration and fix-up results
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   acc_nx, low_nx;
  logic [2*WIDTH-1:0] product, mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_mdu_i && !op_mdu_i[2]) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_LAST)           state_d = S_FIX;
      S_FIX:                                   state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    launch   = 1'b0;
    mt_hi_wr = 1'b0;
    mt_lo_wr = 1'b0;
    iterate  = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        launch   = start_mdu_i && !op_mdu_i[2];
        mt_hi_wr = start_mdu_i && (op_mdu_i == OP_MTHI);
        mt_lo_wr = start_mdu_i && (op_mdu_i == OP_MTLO);
      end
      S_CALC:  iterate = 1'b1;
      S_FIX:   finish  = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes; op[0]=0 selects the signed variants
  always_comb begin
    sign_a = !op_mdu_i[0] && opr_a_mdu_i[WIDTH-1];
    sign_b = !op_mdu_i[0] && opr_b_mdu_i[WIDTH-1];
    abs_a  = sign_a ? -opr_a_mdu_i : opr_a_mdu_i;
    abs_b  = sign_b ? -opr_b_mdu_i : opr_b_mdu_i;
  end

  // One multiply or divide step
  always_comb begin
    mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_q, low_q[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, opnd_q});
    // A successful trial subtraction always leaves a value below the divisor,
    // so the WIDTH-bit modular difference is exact.
    div_sub = rem_sh[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      acc_nx = div_ge ? div_sub : rem_sh[WIDTH-1:0];
      low_nx = {low_q[WIDTH-2:0], div_ge};
    end else begin
      acc_nx = mul_sum[WIDTH:1];
      low_nx = {mul_sum[0], low_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and HI/LO selection for the final cycle
  always_comb begin
    product = {acc_q, low_q};
    mul_res = neg_res_q ? -product : product;
    // Divide-by-zero leaves an all-ones quotient that must not be negated
    quo_res = (neg_res_q && (opnd_q != '0)) ? -low_q : low_q;
    rem_res = neg_rem_q ? -acc_q : acc_q;
    if (is_div_q) begin
      hi_fix = rem_res;
      lo_fix = quo_res;
    end else begin
      hi_fix = mul_res[2*WIDTH-1:WIDTH];
      lo_fix = mul_res[WIDTH-1:0];
    end
  end

  // Iterative datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q    <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (launch) begin
      is_div_q  <= op_mdu_i[1];
      neg_res_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      acc_q     <= '0;
      cnt_q     <= '0;
      opnd_q    <= op_mdu_i[1] ? abs_b : abs_a;
      low_q     <= op_mdu_i[1] ? abs_a : abs_b;
    end else if (iterate) begin
      acc_q <= acc_nx;
      low_q <= low_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Architectural HI/LO plus registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (mt_hi_wr) hi_q <= opr_a_mdu_i;
      if (mt_lo_wr) lo_q <= opr_a_mdu_i;
      if (finish) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
      busy_q <= (state_d != S_IDLE);
      done_q <= finish;
    end
  end

  assign busy_mdu_o = busy_q;
  assign done_mdu_o = done_q;
  assign hi_mdu_o   = hi_q;
  assign lo_mdu_o   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for the mdu against an arithmetic model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        start;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opr_a_mdu_i (a),
    .opr_b_mdu_i (b),
    .op_mdu_i    (op),
    .start_mdu_i (start),
    .busy_mdu_o  (busy),
    .done_mdu_o  (done),
    .hi_mdu_o    (hi),
    .lo_mdu_o    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: plain 64-bit arithmetic, returns {HI, LO}
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] qv, rv;
    logic [63:0] res;
    res = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          qv = q;
          rv = r;
          res = {rv[31:0], qv[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Monitor: pops the scoreboard on every done pulse
  int unsigned busy_cycles = 0;
  logic        busy_prev = 1'b0;
  logic        hold_ok = 1'b1;
  logic [31:0] hold_hi, hold_lo;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      busy_cycles = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        hold_hi = hi;
        hold_lo = lo;
        hold_ok = 1'b1;
        busy_cycles = 0;
      end
      if (busy) begin
        busy_cycles++;
        if (hi !== hold_hi || lo !== hold_lo) hold_ok = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got done=1 expected no result pending");
        end else begin
          e = sb.pop_front();
          check($sformatf("hi_op%0d", e.op), hi, e.hi);
          check($sformatf("lo_op%0d", e.op), lo, e.lo);
          check("busy_cycles", busy_cycles, 32'd33);
          check("hilo_hold", {31'b0, hold_ok}, 32'd1);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit disturb);
    exp_t e;
    logic [63:0] r;
    bit finished;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    r = ref_result(o, x, y);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.op = o;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) begin
      n_chk++;
      $display("FAIL busy_timeout: got busy stuck high expected release within 60 cycles");
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion before 500us");
    $fatal(1);
  end

  initial begin
    logic [31:0] h0, l0;
    start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    // Reset mid-calculation aborts and clears everything asynchronously
    @(negedge clk);
    op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'd1, 32'd3, 32'd5, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd3, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    run_op(3'd3, 32'd5, 32'd0, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    op = 3'd5; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    check("mtlo_done", {31'b0, done}, 32'd0);

    // Reserved opcodes do nothing
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = $urandom;
    @(negedge clk);
    op = 3'd7; a = $urandom;
    @(negedge clk);
    start = 1'b0;
    check("rsvd_hi", hi, h0);
    check("rsvd_lo", lo, l0);
    check("rsvd_busy", {31'b0, busy}, 32'd0);

    // Randomized mul/div with optional disturbance while busy
    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit for the execute stage; sits beside the alu.
- Shares the register-file operand bus (rs/rt) with the alu.
- Owns the architectural HI/LO registers, whose values the writeback mux consumes for MFHI/MFLO.
- Multi-cycle: the control path stalls on busy_mdu_o.

Parameters:
- WIDTH, 32, operand and HI/LO width (only 32 supported)
- ITER, 32, iteration count per mul/div (must equal WIDTH)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- opr_a_mdu_i  input  32  rs operand: multiplicand / dividend / MTHI-MTLO data
- opr_b_mdu_i  input  32  rt operand: multiplier / divisor
- op_mdu_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- start_mdu_i  input  1  request; sampled only when idle
- busy_mdu_o  output  1  high while a mul/div is in flight
- done_mdu_o  output  1  one-cycle pulse when new HI/LO from mul/div is visible
- hi_mdu_o  output  32  HI register
- lo_mdu_o  output  32  LO register

Behaviour:
- Reset (async on rst_n low, released synchronously by design):
  - state=IDLE; hi_mdu_o, lo_mdu_o, busy_mdu_o, done_mdu_o all 0.
  - Reset mid-operation aborts the operation; HI/LO read 0.
- State machine IDLE -> CALC -> FIX -> IDLE.
  - busy_mdu_o = (state != IDLE), registered.
  - done_mdu_o is registered: high exactly the cycle after the FIX edge, else 0.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU (edge E0):
  - Latch operands and op into internal regs.
  - Signed ops store absolute values plus result-sign and remainder-sign flags.
  - Iteration counter = 0; go to CALC.
  - Inputs are ignored after E0 until back in IDLE.
- IDLE, start=1, op MTHI/MTLO:
  - Write opr_a_mdu_i to HI/LO at that edge; stay IDLE.
  - No busy, no done.
- IDLE, start=1, reserved op: no effect.
- start while busy: ignored; never queued.
- CALC: one iteration per cycle, 32 cycles (edges E1..E32), then FIX.
  - Multiply: shift-add on 64-bit {acc, multiplier}. Add multiplicand to acc if LSB=1, then shift right 1 with carry-in from the 33-bit sum.
  - Divide: restoring division. Shift {rem, quotient} left 1; trial-subtract the divisor from the 33-bit rem. If non-negative, keep it and set quotient LSB=1; else restore.
- FIX (edge E33): write HI/LO, go IDLE.
  - Signed ops apply two's-complement negation as required; busy falls and done rises after E33.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder sign = dividend sign.
- Total latency: start edge to HI/LO valid = 33 edges; busy high for 33 cycles.
- Boundary cases:
  - Divide by zero (DIVU): LO = 0xFFFFFFFF, HI = dividend. This is the natural restoring result and is required.
  - DIV by zero: LO = 0xFFFFFFFF, HI = opr_a (original signed value).
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
  - MULT 0x80000000 * 0x80000000: HI = 0x40000000, LO = 0.
  - HI/LO hold their previous values throughout CALC; no partial results are exposed.

Test Plan:
- Reset asserted mid-CALC (cycle 10 after start) -> busy/done/HI/LO = 0 immediately (async). After release, a new MULTU 3*5 gives LO=15, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles, then done pulse 1 cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFF9(-7) * 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> each visible the next cycle, no busy/done. Start pulses and operand changes during busy -> ignored; the in-flight result is unchanged.
